// File: rtl/adder_sched_pkg.sv
// Shared types and default sizing for the round-robin adder scheduler.
package adder_sched_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester above last_grant, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic             found;
    logic [IDX_W-1:0] slot;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        slot      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            slot = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[slot]) begin
                found       = 1'b1;
                grant_idx   = slot;
                grant[slot] = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one registered adder between NUM_REQ requesters,
// one operation in flight at a time (accept -> EXEC -> RESP).
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_carry,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_e              state;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    g_idx;
    logic [DATA_W-1:0]   a_p0;
    logic [DATA_W-1:0]   b_p0;
    logic [DATA_W:0]     sum_p1;
    logic [NUM_REQ-1:0]  vld_p1;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any_req    (pick_any)
    );

    assign sel_a = req_a[int'(pick_idx)*DATA_W +: DATA_W];
    assign sel_b = req_b[int'(pick_idx)*DATA_W +: DATA_W];

    // Accept strobe depends only on state and req_valid, never on resp_ready.
    assign req_ready  = (state == IDLE) ? pick_grant : '0;
    assign busy       = (state != IDLE);
    assign resp_valid = vld_p1;
    assign resp_data  = sum_p1[DATA_W-1:0];
    assign resp_carry = sum_p1[DATA_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LAST_RST;
            g_idx      <= '0;
            a_p0       <= '0;
            b_p0       <= '0;
            sum_p1     <= '0;
            vld_p1     <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                // p0: latch the granted requester's operands
                IDLE: begin
                    if (pick_any) begin
                        a_p0  <= sel_a;
                        b_p0  <= sel_b;
                        g_idx <= pick_idx;
                        state <= EXEC;
                    end
                end
                // p1: registered add, response raised for the granted requester
                EXEC: begin
                    sum_p1 <= add_carry(a_p0, b_p0);
                    vld_p1 <= NUM_REQ'(1) << g_idx;
                    state  <= RESP;
                end
                RESP: begin
                    if (resp_ready[g_idx]) begin
                        vld_p1     <= '0;
                        last_grant <= g_idx;
                        op_count   <= op_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: vector table, hand sequences and
// randomized traffic against a transaction-level scoreboard.
module tb_adder_rr_scheduler;

    localparam int DW = 32;
    localparam int NR = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_a = '0;
    logic [NR*DW-1:0]  req_b = '0;
    logic [NR-1:0]     resp_ready = '0;

    logic [NR-1:0]     req_ready, resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_carry, busy;
    logic [31:0]       op_count;

    logic [NR-1:0]     req_ready_w, resp_valid_w;
    logic [DW-1:0]     resp_data_w;
    logic              resp_carry_w, busy_w;
    logic [3:0]        op_count4;

    adder_rr_scheduler #(.DATA_W(DW), .NUM_REQ(NR), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_carry(resp_carry), .resp_ready(resp_ready), .busy(busy), .op_count(op_count));

    adder_rr_scheduler #(.DATA_W(DW), .NUM_REQ(NR), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready_w), .resp_valid(resp_valid_w), .resp_data(resp_data_w),
        .resp_carry(resp_carry_w), .resp_ready(resp_ready), .busy(busy_w), .op_count(op_count4));

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Scoreboard state: one outstanding transaction at most.
    bit          pending = 1'b0;
    int          pend_g;
    logic [32:0] pend_sum;
    int          acc_cyc;
    int          last_g = NR - 1;
    int          exp_count = 0;
    int          cyc = 0;
    int          w_m;

    typedef struct {
        int          g;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_next(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Sample at the falling edge and run the scoreboard for this cycle.
    task automatic sample();
        @(negedge clock);
        cyc++;
        if (reset) begin
            pending   = 1'b0;
            last_g    = NR - 1;
            exp_count = 0;
        end else begin
            chk("busy", busy, pending);
            chk("op_count", op_count, exp_count);
            chk("op_count_w4", op_count4, exp_count % 16);
            if (!pending) begin
                w_m = rr_next(req_valid, last_g);
                chk("resp_valid_idle", resp_valid, 0);
                chk("req_ready", req_ready, (w_m < 0) ? 0 : (1 << w_m));
                if (w_m >= 0) begin
                    pending  = 1'b1;
                    pend_g   = w_m;
                    pend_sum = {1'b0, req_a[w_m*DW +: DW]} + {1'b0, req_b[w_m*DW +: DW]};
                    acc_cyc  = cyc;
                end
            end else begin
                chk("req_ready_busy", req_ready, 0);
                if (cyc == acc_cyc + 1) begin
                    chk("resp_valid_exec", resp_valid, 0);
                end else begin
                    chk("resp_valid", resp_valid, 1 << pend_g);
                    chk("resp_data", resp_data, pend_sum[31:0]);
                    chk("resp_carry", resp_carry, pend_sum[32]);
                    if (resp_ready[pend_g]) begin
                        pending   = 1'b0;
                        last_g    = pend_g;
                        exp_count = exp_count + 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic wait_accept(output int idx);
        idx = -1;
        for (int n = 0; n < 30; n++) begin
            sample();
            if (req_ready != '0) begin
                idx = $clog2(req_ready);
                return;
            end
            tick();
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: got no req_ready within 30 cycles, required one");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int idx, prev, k4;
        logic [32:0] s;

        tbl[0] = '{2, 32'd5,          32'd7,          32'd12,         1'b0};
        tbl[1] = '{1, 32'hFFFFFFFF,   32'h00000001,   32'h00000000,   1'b1};
        tbl[2] = '{3, 32'h80000000,   32'h80000000,   32'h00000000,   1'b1};
        tbl[3] = '{0, 32'h00000000,   32'h00000000,   32'h00000000,   1'b0};
        tbl[4] = '{2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   1'b1};

        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        sample();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_busy", busy, 0);
        tick();

        // Table vectors: single requester, resp_ready high
        resp_ready = '1;
        for (int v = 0; v < 5; v++) begin
            req_valid = NR'(1) << tbl[v].g;
            req_a[tbl[v].g*DW +: DW] = tbl[v].a;
            req_b[tbl[v].g*DW +: DW] = tbl[v].b;
            sample();
            chk("vec_req_ready", req_ready, 1 << tbl[v].g);
            tick();
            req_valid = '0;
            sample();
            chk("vec_exec_no_resp", resp_valid, 0);
            tick();
            sample();
            chk("vec_resp_valid", resp_valid, 1 << tbl[v].g);
            chk("vec_resp_data", resp_data, tbl[v].sum);
            chk("vec_resp_carry", resp_carry, tbl[v].carry);
            tick();
            sample();
            chk("vec_op_count", op_count, v + 1);
            tick();
        end

        // Fairness: everyone valid from reset
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = 32'(i * 1000 + 17);
            req_b[i*DW +: DW] = 32'hFFFFFF00 + 32'(i * 'h60);
        end
        req_valid  = '1;
        resp_ready = '1;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_accept(idx);
            chk("fair_order", idx, k % NR);
            if (k > 0) chk("fair_interval", cyc - prev, 3);
            prev = cyc;
            tick();
        end
        req_valid = '0;
        repeat (3) step();

        // Back-pressure: stall RESP, other resp_ready bits high must be ignored
        req_valid  = '1;
        resp_ready = '0;
        wait_accept(idx);
        s = {1'b0, req_a[idx*DW +: DW]} + {1'b0, req_b[idx*DW +: DW]};
        tick();
        sample();
        tick();
        resp_ready = ~(NR'(1) << idx);
        for (int n = 0; n < 5; n++) begin
            sample();
            chk("bp_resp_valid", resp_valid, 1 << idx);
            chk("bp_resp_data", resp_data, s[31:0]);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            tick();
        end
        resp_ready = '1;
        sample();
        tick();
        sample();
        chk("bp_next_accept", req_ready, 1 << ((idx + 1) % NR));
        tick();
        req_valid = '0;
        repeat (3) step();

        // Reset while in EXEC
        req_valid = 4'b0001;
        wait_accept(idx);
        tick();
        req_valid = '0;
        reset = 1'b1;
        sample();
        tick();
        reset = 1'b0;
        sample();
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_data", resp_data, 0);
        chk("mid_rst_resp_carry", resp_carry, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        tick();
        req_valid = 4'b1010;
        sample();
        chk("mid_rst_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            req_valid  = NR'($urandom);
            resp_ready = NR'($urandom) | NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_a[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                req_b[i*DW +: DW] = $urandom;
            end
            step();
        end
        req_valid  = '0;
        resp_ready = '1;
        repeat (4) step();

        // Counter wrap: 17 operations on the 4-bit counter build
        do_reset();
        req_valid  = '1;
        resp_ready = '1;
        for (int k = 0; k < 17; k++) begin
            wait_accept(k4);
            tick();
        end
        req_valid = '0;
        repeat (2) step();
        sample();
        chk("wrap_op_count4", op_count4, 1);
        chk("wrap_op_count32", op_count, 17);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at 100000 time units, required finish");
        $fatal(1, "timeout");
    end

endmodule
